// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and feeds decode
// through a registered output slot backed by a one-entry skid buffer.
module fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_valid,
  output logic [63:0] fetch_pc,
  output logic [31:0] fetch_raw_instr
);

  typedef enum logic [1:0] {StReq, StHold, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] inflight_q, inflight_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] fetch_instr_q, fetch_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [63:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        slot_free;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign slot_free  = !fetch_valid_q || !stall;
  assign ireq_valid = !reset && (state_q == StReq || state_q == StDiscard);
  // In DISCARD the bus still sees the address of the request being thrown away.
  assign ireq_addr  = (state_q == StDiscard) ? inflight_q : pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    fetch_valid_d = fetch_valid_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_instr_d = fetch_instr_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;

    if (fetch_valid_q && !stall) begin
      fetch_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      fetch_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
      pc_d          = {redirect_pc[63:2], 2'b00};
      case (state_q)
        StReq: begin
          if (!iresp_data_ok) begin
            inflight_d = pc_q;
            state_d    = StDiscard;
          end
        end
        StHold:    state_d = StReq;
        StDiscard: state_d = iresp_data_ok ? StReq : StDiscard;
        default:   state_d = StReq;
      endcase
    end else begin
      case (state_q)
        StReq: begin
          if (iresp_data_ok) begin
            pc_d = pc_q + PC_STEP;
            if (slot_free) begin
              fetch_valid_d = 1'b1;
              fetch_pc_d    = pc_q;
              fetch_instr_d = iresp_data;
            end else begin
              skid_valid_d = 1'b1;
              skid_pc_d    = pc_q;
              skid_instr_d = iresp_data;
              state_d      = StHold;
            end
          end
        end
        StHold: begin
          if (slot_free) begin
            fetch_valid_d = skid_valid_q;
            fetch_pc_d    = skid_pc_q;
            fetch_instr_d = skid_instr_q;
            skid_valid_d  = 1'b0;
            state_d       = StReq;
          end
        end
        StDiscard: begin
          if (iresp_data_ok) begin
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StReq;
      pc_q          <= PC_RESET;
      inflight_q    <= '0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      fetch_instr_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= '0;
      skid_instr_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_instr_q <= fetch_instr_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
    end
  end

  assign fetch_valid     = fetch_valid_q;
  assign fetch_pc        = fetch_pc_q;
  assign fetch_raw_instr = fetch_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed redirect/reset sequences and a random run
// checked against a queue-based model of the fetched instruction stream.
module tb_fetch_unit;

  localparam logic [63:0] PcReset = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_raw_instr;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_raw_instr(fetch_raw_instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: instructions accepted but not yet consumed by decode, oldest first.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc    = PcReset;
  logic        m_disc  = 1'b0;
  logic [63:0] m_daddr = '0;

  // A request is on the bus unless two instructions are already waiting for decode.
  function automatic logic m_req_act();
    return m_disc || (m_q.size() < 2);
  endfunction

  task automatic m_step();
    logic act;
    act = m_req_act();
    if (reset) begin
      m_q.delete();
      m_pc   = PcReset;
      m_disc = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      if (act && !iresp_data_ok) begin
        if (!m_disc) begin
          m_disc  = 1'b1;
          m_daddr = m_pc;
        end
      end else begin
        m_disc = 1'b0;
      end
      m_pc = {redirect_pc[63:2], 2'b00};
    end else begin
      if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
      if (m_disc) begin
        if (iresp_data_ok) m_disc = 1'b0;
      end else if (act && iresp_data_ok) begin
        m_q.push_back('{pc: m_pc, instr: iresp_data});
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  // Called just after a clock edge: drive inputs, then check the bus request outputs.
  task automatic apply_in(input logic r, input logic dok, input logic [31:0] d, input logic stl,
                          input logic rv, input logic [63:0] rpc);
    logic exp_iv;
    reset          = r;
    iresp_data_ok  = dok;
    iresp_data     = d;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    exp_iv = !r && m_req_act();
    chk("model_ireq_valid", ireq_valid, exp_iv);
    if (exp_iv) chk("model_ireq_addr", ireq_addr, m_disc ? m_daddr : m_pc);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    m_step();
    #1;
    chk("model_fetch_valid", fetch_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("model_fetch_pc", fetch_pc, m_q[0].pc);
      chk("model_fetch_instr", fetch_raw_instr, m_q[0].instr);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        dok;
    logic [31:0] data;
    logic        stl;
    logic        e_iv;
    logic [63:0] e_ia;
    logic        e_fv;
    logic [63:0] e_fpc;
    logic [31:0] e_fi;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic        r, rv, stl, dok;
    logic [63:0] rpc;

    vecs[0] = '{1'b0, 1'b1, 32'd1, 1'b0, 1'b1, 64'h8000_0000, 1'b1, 64'h8000_0000, 32'd1};
    vecs[1] = '{1'b0, 1'b1, 32'd2, 1'b0, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0004, 32'd2};
    vecs[2] = '{1'b0, 1'b1, 32'd3, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 32'd2};
    vecs[3] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0004, 32'd2};
    vecs[4] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0004, 32'd2};
    vecs[5] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0008, 32'd3};
    vecs[6] = '{1'b0, 1'b1, 32'd4, 1'b0, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_000C, 32'd4};
    vecs[7] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0010, 1'b0, 64'h0,         32'd0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      apply_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      chk("rst_ireq_valid", ireq_valid, 1'b0);
      finish_cycle();
    end
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_fetch_pc", fetch_pc, 64'd0);
    chk("rst_fetch_instr", fetch_raw_instr, 64'd0);

    // Zero-latency memory, then a three-cycle stall with the skid buffer filling.
    for (int i = 0; i < 8; i++) begin
      apply_in(vecs[i].rst, vecs[i].dok, vecs[i].data, vecs[i].stl, 1'b0, 64'd0);
      chk($sformatf("vec%0d_ireq_valid", i), ireq_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) chk($sformatf("vec%0d_ireq_addr", i), ireq_addr, vecs[i].e_ia);
      finish_cycle();
      chk($sformatf("vec%0d_fetch_valid", i), fetch_valid, vecs[i].e_fv);
      if (vecs[i].e_fv) begin
        chk($sformatf("vec%0d_fetch_pc", i), fetch_pc, vecs[i].e_fpc);
        chk($sformatf("vec%0d_fetch_instr", i), fetch_raw_instr, vecs[i].e_fi);
      end
    end

    // Redirect while a slow request is in flight.
    apply_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_1000);
    chk("t3_addr_redirect", ireq_addr, 64'h8000_0010);
    finish_cycle();
    apply_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    chk("t3_valid_hold", ireq_valid, 1'b1);
    chk("t3_addr_hold", ireq_addr, 64'h8000_0010);
    finish_cycle();
    apply_in(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0);
    chk("t3_addr_resp", ireq_addr, 64'h8000_0010);
    finish_cycle();
    chk("t3_dropped", fetch_valid, 1'b0);
    apply_in(1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 64'd0);
    chk("t3_new_addr", ireq_addr, 64'h8000_1000);
    finish_cycle();
    chk("t3_new_pc", fetch_pc, 64'h8000_1000);

    // Redirect coinciding with data_ok and an occupied, stalled slot.
    apply_in(1'b0, 1'b1, 32'h0000_1111, 1'b1, 1'b1, 64'h8000_3000);
    chk("t4_addr", ireq_addr, 64'h8000_1004);
    finish_cycle();
    chk("t4_slot_cleared", fetch_valid, 1'b0);
    apply_in(1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 64'd0);
    chk("t4_target_addr", ireq_addr, 64'h8000_3000);
    finish_cycle();
    chk("t4_target_pc", fetch_pc, 64'h8000_3000);
    apply_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    finish_cycle();
    chk("t4_no_stale_skid", fetch_valid, 1'b0);

    // Misaligned redirect target and PC wrap.
    apply_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_2006);
    finish_cycle();
    apply_in(1'b0, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 64'd0);
    chk("t5_discard_addr", ireq_addr, 64'h8000_3004);
    finish_cycle();
    chk("t5_discard_drop", fetch_valid, 1'b0);
    apply_in(1'b0, 1'b1, 32'h0000_2004, 1'b0, 1'b0, 64'd0);
    chk("t5_aligned_addr", ireq_addr, 64'h8000_2004);
    finish_cycle();
    chk("t5_aligned_pc", fetch_pc, 64'h8000_2004);
    apply_in(1'b0, 1'b1, 32'h0000_0077, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    finish_cycle();
    chk("t5_same_cycle_drop", fetch_valid, 1'b0);
    apply_in(1'b0, 1'b1, 32'h0000_FFFC, 1'b0, 1'b0, 64'd0);
    chk("t5_top_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    finish_cycle();
    chk("t5_top_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Reset during an outstanding request with a held slot.
    apply_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    chk("t5_wrap_addr", ireq_addr, 64'd0);
    finish_cycle();
    chk("t6_slot_held", fetch_valid, 1'b1);
    apply_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    chk("t6_rst_ireq_valid", ireq_valid, 1'b0);
    finish_cycle();
    chk("t6_rst_fetch_valid", fetch_valid, 1'b0);
    apply_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    chk("t6_ireq_valid", ireq_valid, 1'b1);
    chk("t6_ireq_addr", ireq_addr, PcReset);
    finish_cycle();

    // Random latency, stalls, redirects and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      stl = ($urandom_range(0, 1) == 1);
      dok = !r && m_req_act() && ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) rpc = {$urandom, $urandom};
      else rpc = {32'd0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
      apply_in(r, dok, $urandom, stl, rv, rpc);
      finish_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage and producer side of the fetch-to-decode interface. It owns the PC and issues word reads on the instruction bus. It presents each returned instruction with its PC as the valid/pc/raw_instr fields of fetch_data_t to the decode stage. It handles downstream stalls with a one-entry skid buffer and handles control-flow redirects, including redirects that arrive while a bus request is still in flight.

Parameters:
PC_RESET, 64'h0000_0000_8000_0000, PC of the first fetch after reset
PC_STEP, 4, PC increment per fetched instruction (32-bit instructions)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ireq_valid  out  1  instruction read request
ireq_addr  out  64  request address; held stable while ireq_valid and not iresp_data_ok
iresp_data_ok  in  1  response for the outstanding request is valid this cycle
iresp_data  in  32  returned instruction word
stall  in  1  decode cannot accept the current fetch output this cycle
redirect_valid  in  1  redirect request from execute/commit
redirect_pc  in  64  redirect target
fetch_valid  out  1  fetch output slot holds an instruction (fetch_data_t.valid)
fetch_pc  out  64  PC of the slot instruction (fetch_data_t.pc)
fetch_raw_instr  out  32  slot instruction (fetch_data_t.raw_instr)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values:
  - pc = PC_RESET; state = REQ.
  - fetch_valid = 0, fetch_pc = 0, fetch_raw_instr = 0.
  - Skid buffer is empty.
  - ireq_valid = 0 during any cycle in which reset is high.
- Combinational request outputs:
  - ireq_valid = !reset && (state==REQ || state==DISCARD).
  - ireq_addr = pc in REQ and HOLD; ireq_addr = the latched in-flight address in DISCARD.
- Slot consumption: the output slot is consumed in any cycle with fetch_valid && !stall. slot_free = !fetch_valid || !stall.
- Redirect handling, highest priority, all states:
  - Clears the slot (fetch_valid<=0) and the skid buffer.
  - Loads pc <= {redirect_pc[63:2], 2'b00}.
- State REQ:
  - No data_ok: hold pc and ireq_addr.
  - data_ok, no redirect, slot_free: slot <= {1, pc, iresp_data}; pc <= pc+PC_STEP; stay REQ. The next request issues the following cycle.
  - data_ok, no redirect, slot busy: skid <= {pc, iresp_data}; pc <= pc+PC_STEP; go HOLD.
  - Redirect with no data_ok in the same cycle: latch in-flight addr; go DISCARD.
  - Redirect with data_ok in the same cycle: drop the response; stay REQ at the new pc.
- State HOLD (no request outstanding, ireq_valid=0):
  - slot_free: slot <= skid; skid emptied; go REQ.
  - Redirect: drop the skid buffer; go REQ.
- State DISCARD (ireq_valid=1 with the old address, bus stability rule):
  - data_ok: drop iresp_data; go REQ with the redirected pc.
  - Further redirect: update pc only; stay in DISCARD.
- Output slot:
  - Holds its value while fetch_valid && stall.
  - Clears to fetch_valid=0 when consumed and nothing is written in that cycle.
- Timing and throughput:
  - Latency from iresp_data_ok to fetch_valid is 1 cycle, because the slot is registered.
  - Peak throughput is 1 instr/cycle when memory asserts data_ok in the same cycle as the request.
- Boundary conditions:
  - pc+PC_STEP wraps modulo 2^64.
  - stall while fetch_valid=0 has no effect.
  - Reset asserted mid-request forces REQ with pc=PC_RESET. No response is discarded across reset, because the bus is reset together with this block.
  - At most one request is outstanding. No instruction is duplicated or lost except those dropped by a redirect.

Test Plan:
1. Reset, then memory returns instr=k in the same cycle as each request, stall=0 → ireq_addr 0x80000000, 0x80000004, 0x80000008. fetch_valid=1 from cycle 2 with matching pc/raw_instr, one instruction per cycle.
2. Stall=1 for 3 cycles while memory keeps answering → slot holds 0x80000004. Skid holds 0x80000008, ireq_valid=0 in HOLD. On release, outputs are 0x80000004 then 0x80000008, with no gap or duplicate.
3. Memory with 3-cycle latency, redirect_pc=0x80001000 in the cycle after the request to 0x80000010 → ireq_addr stays 0x80000010 until data_ok. That response is dropped. The next request is to 0x80001000, and fetch_valid never shows 0x80000010.
4. Redirect in the same cycle as data_ok and an occupied slot → slot cleared, skid empty. The next ireq_addr is the redirect target.
5. Redirect_pc=0x80002006 → the fetched PC is 0x80002004. Separately, pc=64'hFFFF_FFFF_FFFF_FFFC fetch → next ireq_addr is 0.
6. Assert reset for 1 cycle during an outstanding request with fetch_valid=1 → fetch_valid=0, ireq_valid=0 in that cycle. The next request is to 0x80000000.
